// File: rtl/nwc_pkg.sv
// -----------------------------------------------------------------------------
// nwc_pkg
// Shared definitions for the NWC multiplication sequencer.
//   WORD_W      : packed operand/result word width (two coefficients)
//   COEFF_W     : width of one coefficient; the low coefficient sits in [29:0]
//   nwc_state_e : sequencer state encoding
// No ports (package).
// -----------------------------------------------------------------------------
package nwc_pkg;

    localparam int WORD_W  = 60;
    localparam int COEFF_W = 30;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT,
        S_DRAIN,
        S_DONE
    } nwc_state_e;

endpackage

// File: rtl/nwc_watchdog.sv
// -----------------------------------------------------------------------------
// nwc_watchdog
// Saturating cycle counter that flags expiry once i_enable has been held for
// TIMEOUT_CYCLES consecutive cycles since the last i_clear.
// Ports:
//   clk        in  rising-edge clock
//   rst_n      in  asynchronous active-low reset
//   i_enable   in  count this cycle
//   i_clear    in  synchronous counter clear (wins over i_enable)
//   o_expired  out high in the TIMEOUT_CYCLES-th enabled cycle and after
// Only instantiated when NWC_SEQ_WATCHDOG_EN is defined.
// -----------------------------------------------------------------------------
module nwc_watchdog #(
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_enable,
    input  logic i_clear,
    output logic o_expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable && (r_cnt != CNT_W'(TIMEOUT_CYCLES))) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // r_cnt counts enabled cycles already elapsed, so the current cycle is
    // number r_cnt+1; expire on the TIMEOUT_CYCLES-th one.
    assign o_expired = i_enable && (r_cnt >= CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/nwc_sequencer.sv
// -----------------------------------------------------------------------------
// nwc_sequencer
// Streams N_WORDS operand word pairs into the NWC processor, pulses start,
// then collects N_WORDS result words back out as a registered stream.
// Optional feature macro: NWC_SEQ_WATCHDOG_EN (adds a timeout in WAIT).
// Ports:
//   clk, rst_n                  clock / async active-low reset
//   go                          one-cycle run request (honoured in IDLE only)
//   in_valid, in_ready          operand handshake (ready only in LOAD)
//   in_a, in_b                  operand words
//   proc_data_in0/1             registered operand words to the processor
//   proc_write_enable           one cycle per accepted operand pair
//   proc_start                  one-cycle start pulse after loading
//   proc_data_out               processor result word
//   proc_output_active          processor result strobe
//   out_valid, out_data         result stream, one cycle behind the processor
//   busy                        not IDLE
//   done, err                   single-cycle status pulses
// -----------------------------------------------------------------------------
module nwc_sequencer
    import nwc_pkg::*;
#(
    parameter int N_WORDS        = 2048,
    parameter int WORD_W         = nwc_pkg::WORD_W,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              go,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_a,
    input  logic [WORD_W-1:0] in_b,
    output logic [WORD_W-1:0] proc_data_in0,
    output logic [WORD_W-1:0] proc_data_in1,
    output logic              proc_write_enable,
    output logic              proc_start,
    input  logic [WORD_W-1:0] proc_data_out,
    input  logic              proc_output_active,
    output logic              out_valid,
    output logic [WORD_W-1:0] out_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int CNT_W = $clog2(N_WORDS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_WORDS - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(N_WORDS);

    nwc_state_e        r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_wr_cnt, w_wr_cnt_nxt;
    logic [CNT_W-1:0]  r_rd_cnt, w_rd_cnt_nxt;
    logic [WORD_W-1:0] r_d0, w_d0_nxt;
    logic [WORD_W-1:0] r_d1, w_d1_nxt;
    logic [WORD_W-1:0] r_od, w_od_nxt;
    logic              r_we, w_we_nxt;
    logic              r_start, w_start_nxt;
    logic              r_ov, w_ov_nxt;
    logic              r_err, w_err_nxt;
    logic              w_hs;
    logic              w_capture;

`ifdef NWC_SEQ_WATCHDOG_EN
    logic w_wd_en;
    logic w_wd_clr;
    logic w_wd_expired;

    assign w_wd_en  = (r_state == S_WAIT);
    assign w_wd_clr = (r_state != S_WAIT);

    nwc_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_enable  (w_wd_en),
        .i_clear   (w_wd_clr),
        .o_expired (w_wd_expired)
    );
`endif

    assign w_hs = in_valid && (r_state == S_LOAD);

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt  = r_state;
        w_wr_cnt_nxt = r_wr_cnt;
        w_rd_cnt_nxt = r_rd_cnt;
        w_d0_nxt     = r_d0;
        w_d1_nxt     = r_d1;
        w_od_nxt     = r_od;
        w_we_nxt     = 1'b0;
        w_start_nxt  = 1'b0;
        w_ov_nxt     = 1'b0;
        w_err_nxt    = 1'b0;
        w_capture    = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_err_nxt = proc_output_active;
                if (go) begin
                    w_state_nxt  = S_LOAD;
                    w_wr_cnt_nxt = '0;
                    w_rd_cnt_nxt = '0;
                end
            end

            S_LOAD: begin
                w_err_nxt = proc_output_active;
                if (w_hs) begin
                    w_d0_nxt = in_a;
                    w_d1_nxt = in_b;
                    w_we_nxt = 1'b1;
                    if (r_wr_cnt != CNT_FULL) begin
                        w_wr_cnt_nxt = r_wr_cnt + CNT_W'(1);
                    end
                    if (r_wr_cnt == CNT_LAST) begin
                        w_state_nxt = S_START;
                    end
                end
            end

            S_START: begin
                w_err_nxt   = proc_output_active;
                w_start_nxt = 1'b1;
                w_state_nxt = S_WAIT;
            end

            S_WAIT: begin
                if (proc_output_active) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_DRAIN;
                end
`ifdef NWC_SEQ_WATCHDOG_EN
                else if (w_wd_expired) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_DONE;
                end
`endif
            end

            S_DRAIN: begin
                if (proc_output_active) begin
                    w_capture = 1'b1;
                end else begin
                    // Stream ended early: rd_cnt cannot be full here, since
                    // reaching N_WORDS already left DRAIN.
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end

            S_DONE: begin
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Shared result capture for the first word (WAIT) and the rest (DRAIN).
        if (w_capture && (r_rd_cnt != CNT_FULL)) begin
            w_od_nxt     = proc_data_out;
            w_ov_nxt     = 1'b1;
            w_rd_cnt_nxt = r_rd_cnt + CNT_W'(1);
            if (r_rd_cnt == CNT_LAST) begin
                w_state_nxt = S_DONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_wr_cnt <= '0;
            r_rd_cnt <= '0;
            r_d0     <= '0;
            r_d1     <= '0;
            r_od     <= '0;
            r_we     <= 1'b0;
            r_start  <= 1'b0;
            r_ov     <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_wr_cnt <= w_wr_cnt_nxt;
            r_rd_cnt <= w_rd_cnt_nxt;
            r_d0     <= w_d0_nxt;
            r_d1     <= w_d1_nxt;
            r_od     <= w_od_nxt;
            r_we     <= w_we_nxt;
            r_start  <= w_start_nxt;
            r_ov     <= w_ov_nxt;
            r_err    <= w_err_nxt;
        end
    end

    assign in_ready          = (r_state == S_LOAD);
    assign busy              = (r_state != S_IDLE);
    assign done              = (r_state == S_DONE);
    assign err               = r_err;
    assign proc_data_in0     = r_d0;
    assign proc_data_in1     = r_d1;
    assign proc_write_enable = r_we;
    assign proc_start        = r_start;
    assign out_valid         = r_ov;
    assign out_data          = r_od;

endmodule

// File: tb/tb_nwc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_nwc_sequencer
// Self-checking bench for nwc_sequencer: a control-vector table from IDLE,
// then full load/drain runs, an early-drop run, a mid-load reset and the
// WAIT behaviour (timeout when NWC_SEQ_WATCHDOG_EN is defined).
// Inputs change on the falling edge; outputs are sampled on the next falling
// edge, i.e. they reflect the rising edge in between.
// -----------------------------------------------------------------------------
module tb_nwc_sequencer;

    localparam int N_WORDS        = 2048;
    localparam int WORD_W         = 60;
    localparam int TIMEOUT_CYCLES = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              go = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [WORD_W-1:0] in_a = '0;
    logic [WORD_W-1:0] in_b = '0;
    logic [WORD_W-1:0] proc_data_in0;
    logic [WORD_W-1:0] proc_data_in1;
    logic              proc_write_enable;
    logic              proc_start;
    logic [WORD_W-1:0] proc_data_out = '0;
    logic              proc_output_active = 1'b0;
    logic              out_valid;
    logic [WORD_W-1:0] out_data;
    logic              busy;
    logic              done;
    logic              err;

    always #5 clk = ~clk;

    nwc_sequencer #(
        .N_WORDS        (N_WORDS),
        .WORD_W         (WORD_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .go                 (go),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .in_a               (in_a),
        .in_b               (in_b),
        .proc_data_in0      (proc_data_in0),
        .proc_data_in1      (proc_data_in1),
        .proc_write_enable  (proc_write_enable),
        .proc_start         (proc_start),
        .proc_data_out      (proc_data_out),
        .proc_output_active (proc_output_active),
        .out_valid          (out_valid),
        .out_data           (out_data),
        .busy               (busy),
        .done               (done),
        .err                (err)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model of the operand registers' held values.
    logic [WORD_W-1:0] m_d0 = '0;
    logic [WORD_W-1:0] m_d1 = '0;

    typedef struct {
        logic go;
        logic act;
        logic e_busy;
        logic e_ready;
        logic e_err;
        logic e_done;
        logic e_we;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [WORD_W-1:0] pat_a(input int i);
        return {30'(i * 5 + 1), 30'(i)};
    endfunction

    function automatic logic [WORD_W-1:0] pat_b(input int i);
        return {30'(i ^ 32'h155), 30'(i * 3 + 7)};
    endfunction

    function automatic logic [WORD_W-1:0] pat_d(input int k);
        return {30'(k + 100), 30'(k * 11 + 2)};
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_we"},       proc_write_enable, 0);
        check({tag, "_start"},    proc_start, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_busy"},     busy, 0);
        check({tag, "_done"},     done, 0);
        check({tag, "_err"},      err, 0);
        check({tag, "_d0"},       proc_data_in0, 0);
        check({tag, "_d1"},       proc_data_in1, 0);
        check({tag, "_out_data"}, out_data, 0);
    endtask

    // Called on a falling edge while IDLE.
    task automatic go_cmd(input string tag);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        check({tag, "_busy_after_go"},  busy, 1);
        check({tag, "_ready_after_go"}, in_ready, 1);
    endtask

    // Streams n_target operand pairs, optionally with in_valid toggling.
    task automatic do_load(input bit toggle, input int n_target, input string tag);
        int sent = 0;
        int cyc = 0;
        int n_we = 0;
        int n_bad = 0;
        bit v;
        while (sent < n_target && cyc < 4 * N_WORDS) begin
            v = toggle ? ((cyc % 2) == 0) : 1'b1;
            in_valid = v;
            in_a = pat_a(sent);
            in_b = pat_b(sent);
            if (in_ready !== 1'b1) n_bad++;
            @(negedge clk);
            if (v) begin
                m_d0 = pat_a(sent);
                m_d1 = pat_b(sent);
                sent++;
            end
            if (proc_write_enable !== v) n_bad++;
            if (proc_write_enable === 1'b1) n_we++;
            if (proc_data_in0 !== m_d0 || proc_data_in1 !== m_d1) n_bad++;
            if (proc_start !== 1'b0) n_bad++;
            cyc++;
        end
        in_valid = 1'b0;
        check({tag, "_we_count"},  n_we, n_target);
        check({tag, "_bad_cycles"}, n_bad, 0);
    endtask

    // Right after the last write cycle has been observed.
    task automatic check_start(input string tag);
        check({tag, "_ready_low"},   in_ready, 0);
        check({tag, "_start_early"}, proc_start, 0);
        @(negedge clk);
        check({tag, "_start_pulse"}, proc_start, 1);
        check({tag, "_we_off"},      proc_write_enable, 0);
        check({tag, "_busy_wait"},   busy, 1);
    endtask

    // Processor model: n_emit words (plus extra beyond N_WORDS), one per cycle.
    task automatic do_drain(input int n_emit, input int extra, input string tag);
        int n_ov = 0;
        int n_bad = 0;
        int n_done = 0;
        int n_err = 0;
        for (int k = 0; k < n_emit + extra; k++) begin
            proc_output_active = 1'b1;
            proc_data_out = pat_d(k);
            @(negedge clk);
            if (k < N_WORDS) begin
                if (out_valid !== 1'b1 || out_data !== pat_d(k)) n_bad++;
            end else begin
                if (out_valid !== 1'b0) n_bad++;
            end
            if (done !== (k == N_WORDS - 1)) n_bad++;
            if (out_valid === 1'b1) n_ov++;
            if (done === 1'b1) n_done++;
            if (err === 1'b1) n_err++;
        end
        proc_output_active = 1'b0;
        if (n_emit >= N_WORDS) begin
            check({tag, "_ov_count"},   n_ov, N_WORDS);
            check({tag, "_bad_cycles"}, n_bad, 0);
            check({tag, "_done_count"}, n_done, 1);
            check({tag, "_err_count"},  n_err, 0);
            @(negedge clk);
            check({tag, "_idle_busy"}, busy, 0);
            check({tag, "_idle_err"},  err, 0);
            check({tag, "_idle_done"}, done, 0);
            check({tag, "_idle_ov"},   out_valid, 0);
        end else begin
            check({tag, "_ov_count"},   n_ov, n_emit);
            check({tag, "_bad_cycles"}, n_bad, 0);
            check({tag, "_err_before"}, n_err, 0);
            @(negedge clk);
            check({tag, "_err_pulse"},  err, 1);
            check({tag, "_done_pulse"}, done, 1);
            check({tag, "_ov_off"},     out_valid, 0);
            @(negedge clk);
            check({tag, "_idle_busy"}, busy, 0);
            check({tag, "_idle_err"},  err, 0);
            check({tag, "_idle_done"}, done, 0);
        end
    endtask

    initial begin
        #10000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        //            go    act   busy  ready err   done  we
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

        // Reset state.
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Control table: err in IDLE, go into LOAD, err in LOAD, go ignored.
        for (int i = 0; i < 6; i++) begin
            go = vecs[i].go;
            proc_output_active = vecs[i].act;
            @(negedge clk);
            check($sformatf("vec%0d_busy", i),  busy, vecs[i].e_busy);
            check($sformatf("vec%0d_ready", i), in_ready, vecs[i].e_ready);
            check($sformatf("vec%0d_err", i),   err, vecs[i].e_err);
            check($sformatf("vec%0d_done", i),  done, vecs[i].e_done);
            check($sformatf("vec%0d_we", i),    proc_write_enable, vecs[i].e_we);
        end
        go = 1'b0;
        proc_output_active = 1'b0;

        // Run 1: toggled in_valid, full drain with one extra word.
        do_load(1'b1, N_WORDS, "load_toggle");
        check_start("run1");
        do_drain(N_WORDS, 1, "drain_full");

        // Run 2: back-to-back load, processor drops out after 100 words.
        go_cmd("run2");
        do_load(1'b0, N_WORDS, "load_b2b");
        check_start("run2");
        do_drain(100, 0, "drain_drop");

        // Run 3: reset in the middle of loading.
        go_cmd("run3");
        do_load(1'b0, 500, "load_500");
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        m_d0 = '0;
        m_d1 = '0;
        @(negedge clk);
        check("post_reset_busy", busy, 0);
        check("post_reset_done", done, 0);
        check("post_reset_ready", in_ready, 0);

        // Run 4: clean run after reset, then WAIT with a silent processor.
        go_cmd("run4");
        do_load(1'b0, N_WORDS, "load_after_reset");
        check_start("run4");
`ifdef NWC_SEQ_WATCHDOG_EN
        begin
            int n_bad = 0;
            for (int k = 1; k <= TIMEOUT_CYCLES; k++) begin
                @(negedge clk);
                if (k < TIMEOUT_CYCLES && (err !== 1'b0 || done !== 1'b0)) n_bad++;
            end
            check("wd_early_pulse", n_bad, 0);
            check("wd_err", err, 1);
            check("wd_done", done, 1);
            @(negedge clk);
            check("wd_idle_busy", busy, 0);
            check("wd_idle_err", err, 0);
        end
`else
        begin
            int n_bad = 0;
            repeat (40) begin
                @(negedge clk);
                if (busy !== 1'b1 || err !== 1'b0 || done !== 1'b0) n_bad++;
            end
            check("wait_hold_bad", n_bad, 0);
            do_drain(N_WORDS, 0, "drain_after_wait");
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
